issue_ctrl: RTL

Dispatch sequencer between the instruction decoder and the back end (ROB, reservation station, load/store buffer). It holds one decoded instruction and issues it in a single cycle to the ROB plus exactly one of RS/LSB when both targets have space. It tags the instruction with the ROB tail index and updates the rename table. It absorbs back-pressure so the decoder sees a simple valid/ready handshake, and drops everything on `clear`.

---
 rtl/issue_ctrl_pkg.sv | 30 +++
 rtl/issue_skid.sv | 35 +++
 rtl/issue_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared widths, opcode constants, skid state type and the is_mem/has_rd classifiers
package issue_ctrl_pkg;
  localparam int OpSize = 6;
  localparam int RegAddrSize = 5;
  localparam int InstSize = 32;
  localparam logic zero = 1'b0;
  localparam logic one = 1'b1;
  localparam logic [OpSize-1:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
  localparam logic [OpSize-1:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
  localparam logic [OpSize-1:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [OpSize-1:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;
  localparam logic [OpSize-1:0] ADDI = 6'd19, SLTI = 6'd20, XORI = 6'd21, ORI = 6'd22, ANDI = 6'd23;
  localparam logic [OpSize-1:0] ADD = 6'd24, SUB = 6'd25, AND = 6'd26, OR = 6'd27;
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic [OpSize-1:0] op;
    logic [RegAddrSize-1:0] rd;
    logic [RegAddrSize-1:0] rs1;
    logic [RegAddrSize-1:0] rs2;
    logic [InstSize-1:0] imm;
    logic [InstSize-1:0] pc;
  } payload_t;
  // Loads and stores occupy the contiguous LB..SW code range.
  function automatic logic op_is_mem(input logic [OpSize-1:0] op);
    return op inside {[LB:SW]};
  endfunction
  function automatic logic op_has_rd(input logic [OpSize-1:0] op, input logic [RegAddrSize-1:0] rd);
    return !(op inside {[BEQ:BGEU], [SB:SW]}) && rd != '0;
  endfunction
endpackage

// File: rtl/issue_skid.sv
// issue_skid: one-entry EMPTY/FULL holding buffer with load, unload and flush
// Ports: clk_i/rst_i clock and sync reset, rdy_i global enable, flush_i drop content,
//        load_i capture d_i, unload_i entry consumed, q_o held entry, full_o state is FULL.
module issue_skid import issue_ctrl_pkg::*; #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rdy_i,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         full_o
);
  state_t state_q, state_d;
  logic [W-1:0] data_q, data_d;
  // A load wins over an unload so a simultaneous issue and accept keeps the entry FULL.
  always_comb begin
    state_d = flush_i ? EMPTY : load_i ? FULL : unload_i ? EMPTY : state_q;
    data_d = (load_i && !flush_i) ? d_i : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q <= '0;
    end else if (rdy_i) begin
      state_q <= state_d;
      data_q <= data_d;
    end
  end
  assign q_o = data_q;
  assign full_o = state_q == FULL;
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: holds one decoded instruction and issues it to the ROB plus RS or LSB
// Ports: clk_in/rst_in clock and sync reset, rdy_in global enable, clear flush,
//        dec_* decoder valid/ready handshake and payload, rob/rs/lsb_full capacity flags,
//        rob_tail next ROB tag, *_we registered write strobes, iss_* issued payload,
//        rat_* rename-table write. Optional ISSUE_STAT_EN adds stat_issue/stat_stall counters.
module issue_ctrl import issue_ctrl_pkg::*; #(
  parameter int ROB_TAG_W = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [OpSize-1:0]      dec_op,
  input  logic [RegAddrSize-1:0] dec_rd,
  input  logic [RegAddrSize-1:0] dec_rs1,
  input  logic [RegAddrSize-1:0] dec_rs2,
  input  logic [InstSize-1:0]    dec_imm,
  input  logic [InstSize-1:0]    dec_pc,
  input  logic                   rob_full,
  input  logic                   rs_full,
  input  logic                   lsb_full,
  input  logic [ROB_TAG_W-1:0]   rob_tail,
  output logic                   rob_we,
  output logic                   rs_we,
  output logic                   lsb_we,
  output logic [OpSize-1:0]      iss_op,
  output logic [RegAddrSize-1:0] iss_rd,
  output logic [RegAddrSize-1:0] iss_rs1,
  output logic [RegAddrSize-1:0] iss_rs2,
  output logic [InstSize-1:0]    iss_imm,
  output logic [InstSize-1:0]    iss_pc,
  output logic [ROB_TAG_W-1:0]   iss_tag,
  output logic                   rat_we,
  output logic [RegAddrSize-1:0] rat_rd,
  output logic [ROB_TAG_W-1:0]   rat_tag
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0]            stat_issue,
  output logic [31:0]            stat_stall
`endif
);
  localparam int PW = $bits(payload_t);
  payload_t dec_p, buf_p;
  logic [PW:0] buf_q;
  logic buf_mem, buf_full, can_issue, iss_go, hs;
  assign dec_p = '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm, pc: dec_pc};
  assign buf_mem = buf_q[PW];
  assign buf_p = buf_q[PW-1:0];
  assign can_issue = buf_full && !rob_full && !(buf_mem ? lsb_full : rs_full);
  // Pass-through: the slot is free again in the same cycle it issues.
  assign dec_ready = !clear && (!buf_full || can_issue);
  assign hs = dec_valid && dec_ready && rdy_in;
  assign iss_go = can_issue && !clear;
  issue_skid #(.W(PW + 1)) u_skid (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .rdy_i   (rdy_in),
    .flush_i (clear),
    .load_i  (hs),
    .unload_i(can_issue),
    .d_i     ({op_is_mem(dec_op), dec_p}),
    .q_o     (buf_q),
    .full_o  (buf_full)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      {rob_we, rs_we, lsb_we, rat_we} <= '0;
      {iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc} <= '0;
      iss_tag <= '0;
      rat_rd <= '0;
      rat_tag <= '0;
    end else if (rdy_in) begin
      rob_we <= iss_go;
      rs_we <= iss_go && !buf_mem;
      lsb_we <= iss_go && buf_mem;
      rat_we <= iss_go && op_has_rd(buf_p.op, buf_p.rd);
      if (iss_go) begin
        {iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc} <= buf_p;
        iss_tag <= rob_tail;
        rat_rd <= buf_p.rd;
        rat_tag <= rob_tail;
      end
    end else begin
      {rob_we, rs_we, lsb_we, rat_we} <= '0;
    end
  end
`ifdef ISSUE_STAT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else if (rdy_in) begin
      stat_issue <= stat_issue + {31'd0, iss_go};
      stat_stall <= stat_stall + {31'd0, buf_full && !can_issue};
    end
  end
`endif
endmodule
